// File: rtl/alu_pkg.sv
// Shared types and constants for the RV32I integer ALU.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_SLL  = 4'b0010,
        ALU_SLT  = 4'b0011,
        ALU_SLTU = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_OR   = 4'b1000,
        ALU_AND  = 4'b1001
    } alu_op_e;

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_mode_e;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter covering SLL, SRL and SRA.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = XLEN_DEFAULT,
    parameter int SHAMT_WL = $clog2(XLEN)
) (
    input  logic [XLEN-1:0]     data_i,
    input  logic [SHAMT_WL-1:0] shamt_i,
    input  shift_mode_e         mode_i,
    output logic [XLEN-1:0]     data_o
);

    always_comb begin
        data_o = '0;
        case (mode_i)
            SH_SLL:  data_o = data_i << shamt_i;
            SH_SRL:  data_o = data_i >> shamt_i;
            SH_SRA:  data_o = $unsigned($signed(data_i) >>> shamt_i);
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// RV32I integer ALU with a single registered result stage.
// Optional registered zero flag enabled by defining ALU_ZERO_FLAG_EN.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic [XLEN-1:0] r1,
    input  logic [XLEN-1:0] r2,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] alu_result
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic            zero_o
`endif
);

    localparam int SHAMT_WL = $clog2(XLEN);

    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [XLEN-1:0] shift_result;
    shift_mode_e     shift_mode;

    always_comb begin
        shift_mode = SH_SRL;
        if (alu_control == ALU_SLL) begin
            shift_mode = SH_SLL;
        end else if (alu_control == ALU_SRA) begin
            shift_mode = SH_SRA;
        end
    end

    // Only the low shift-amount bits of r2 reach the shifter.
    alu_shifter #(
        .XLEN     (XLEN),
        .SHAMT_WL (SHAMT_WL)
    ) u_shifter (
        .data_i  (r1),
        .shamt_i (r2[SHAMT_WL-1:0]),
        .mode_i  (shift_mode),
        .data_o  (shift_result)
    );

    always_comb begin
        alu_result_d = '0;
        case (alu_control)
            ALU_ADD:  alu_result_d = r1 + r2;
            ALU_SUB:  alu_result_d = r1 - r2;
            ALU_SLL:  alu_result_d = shift_result;
            ALU_SLT:  alu_result_d = {{(XLEN-1){1'b0}}, ($signed(r1) < $signed(r2))};
            ALU_SLTU: alu_result_d = {{(XLEN-1){1'b0}}, (r1 < r2)};
            ALU_XOR:  alu_result_d = r1 ^ r2;
            ALU_SRL:  alu_result_d = shift_result;
            ALU_SRA:  alu_result_d = shift_result;
            ALU_OR:   alu_result_d = r1 | r2;
            ALU_AND:  alu_result_d = r1 & r2;
            default:  alu_result_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            alu_result_q <= '0;
        end else begin
            alu_result_q <= alu_result_d;
        end
    end

    assign alu_result = alu_result_q;

`ifdef ALU_ZERO_FLAG_EN
    logic zero_d, zero_q;

    assign zero_d = (alu_result_d == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign zero_o = zero_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered RV32I ALU.
`timescale 1ns/1ps
module tb_alu;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
`ifdef ALU_ZERO_FLAG_EN
    logic        zero_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    alu #(.XLEN(32)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .r1          (r1),
        .r2          (r2),
        .alu_control (alu_control),
        .alu_result  (alu_result)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero_o      (zero_o)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic check_zero(input string tag, input logic [31:0] exp_res);
`ifdef ALU_ZERO_FLAG_EN
        check({tag, ".zero"}, {31'd0, zero_o}, {31'd0, (exp_res == 32'd0)});
`endif
    endtask

    // Drive one operation at the falling edge, check result just after the next rising edge.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        @(negedge clk_i);
        alu_control = op;
        r1 = a;
        r2 = b;
        @(posedge clk_i);
        #1;
        check(tag, alu_result, exp);
        check_zero(tag, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i     = 1'b1;
        r1          = 32'd5;
        r2          = 32'd3;
        alu_control = 4'b0000;

        // Reset held two cycles with ADD 5+3 presented
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            check("reset_hold", alu_result, 32'd0);
`ifdef ALU_ZERO_FLAG_EN
            check("reset_hold.zero", {31'd0, zero_o}, 32'd1);
`endif
        end
        @(negedge clk_i);
        reset_i = 1'b0;
        check("reset_release_pre", alu_result, 32'd0);
        @(posedge clk_i);
        #1;
        check("reset_release_add", alu_result, 32'd8);

        // Reset asserted between edges must not act until the next edge
        @(negedge clk_i);
        reset_i = 1'b1;
        #2;
        check("reset_sync_wait", alu_result, 32'd8);
        @(posedge clk_i);
        #1;
        check("reset_sync_hit", alu_result, 32'd0);
        @(negedge clk_i);
        reset_i = 1'b0;

        run_op("add_wrap",   4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
        run_op("sub_wrap",   4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        run_op("sub_eq",     4'b0001, 32'd7,         32'd7,         32'd0);
        run_op("slt_neg",    4'b0011, 32'hFFFF_FFFF, 32'd1,         32'd1);
        run_op("sltu_big",   4'b0100, 32'hFFFF_FFFF, 32'd1,         32'd0);
        run_op("slt_bound",  4'b0011, 32'h8000_0000, 32'h7FFF_FFFF, 32'd1);
        run_op("sltu_bound", 4'b0100, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0);
        run_op("slt_eq",     4'b0011, 32'd5,         32'd5,         32'd0);
        run_op("sltu_eq",    4'b0100, 32'd5,         32'd5,         32'd0);
        run_op("sltu_less",  4'b0100, 32'd1,         32'hFFFF_FFFF, 32'd1);
        run_op("sll_31",     4'b0010, 32'd1,         32'd31,        32'h8000_0000);
        run_op("sll_mask",   4'b0010, 32'd1,         32'h0000_0021, 32'd2);
        run_op("sll_zero",   4'b0010, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678);
        run_op("srl_4",      4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000);
        run_op("sra_4",      4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000);
        run_op("sra_mask",   4'b0111, 32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
        run_op("sra_pos",    4'b0111, 32'h4000_0000, 32'd4,         32'h0400_0000);
        run_op("xor",        4'b0101, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        run_op("or",         4'b1000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        run_op("and",        4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        run_op("rsvd_1111",  4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
        run_op("rsvd_1010",  4'b1010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);

        // Back-to-back ops: each result appears exactly one edge after its inputs
        run_op("pipe_add", 4'b0000, 32'd12, 32'd10, 32'd22);
        @(negedge clk_i);
        alu_control = 4'b0001;
        check("pipe_hold_add", alu_result, 32'd22);
        @(posedge clk_i);
        #1;
        check("pipe_sub", alu_result, 32'd2);
        @(negedge clk_i);
        alu_control = 4'b1001;
        check("pipe_hold_sub", alu_result, 32'd2);
        @(posedge clk_i);
        #1;
        check("pipe_and", alu_result, 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- RV32I integer ALU used by the execute stage.
- Applies one of ten operations, selected by a 4-bit `alu_control` code, to two operands `r1` and `r2`.
- Result is registered: one clock of latency, cleared by synchronous reset.
- The execute stage samples `alu_result` a fixed number of cycles after presenting operands, so the 1-cycle latency is transparent to it.

Parameters:
- XLEN, 32, operand/result width; shift amount width is $clog2(XLEN) (5 at default).

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- r1  input  XLEN  operand A (rs1 value).
- r2  input  XLEN  operand B (rs2 value or immediate, already extended by decode).
- alu_control  input  4  operation select.
- alu_result  output  XLEN  registered result.

Behaviour:
- Reset: on a rising clk_i with reset_i=1, `alu_result` <= 0 (and `zero_o` <= 1 if present). Reset takes priority over any operation. Reset is synchronous only: asserting reset_i between edges has no effect until the next edge.
- Latency: inputs sampled on rising edge N; the result is visible from edge N to edge N+1. Back-to-back operations are supported, one per cycle, with no handshake and no stall.
- Opcodes (`alu_control`):
  - 0000 ADD: r1+r2, mod 2^XLEN, carry discarded.
  - 0001 SUB: r1-r2, mod 2^XLEN.
  - 0010 SLL: r1 << r2[4:0].
  - 0011 SLT: 1 if signed(r1) < signed(r2), else 0; zero-extended to XLEN.
  - 0100 SLTU: 1 if unsigned r1 < r2, else 0.
  - 0101 XOR: r1 ^ r2.
  - 0110 SRL: logical r1 >> r2[4:0].
  - 0111 SRA: arithmetic r1 >>> r2[4:0], sign bit replicated.
  - 1000 OR: r1 | r2.
  - 1001 AND: r1 & r2.
  - 1010-1111 reserved: result 0, no error signalled.
- Shift rules: only the low $clog2(XLEN) bits of r2 are used; upper bits are ignored. Shift by 0 returns r1 unchanged.
- Overflow: ADD/SUB wrap silently, e.g. 0x7FFFFFFF+1 = 0x80000000, 0-1 = 0xFFFFFFFF.
- Signed compare boundary: SLT(0x80000000, 0x7FFFFFFF)=1; SLTU of the same operands = 0. Equal operands give 0 for both.
- Structure: the datapath is purely combinational and feeds a single output register. No X propagation from reserved codes.

Optional Feature:
- Macro ALU_ZERO_FLAG_EN.
- Defined: adds output port `zero_o` (1 bit), registered with the same timing as `alu_result`. `zero_o` = 1 when the next `alu_result` is all zeros. Reset value is 1. Intended for branch resolution (BEQ/BNE via SUB).
- Undefined: port and logic absent; remaining behaviour identical.

Decomposition:
- Package `alu_pkg`:
  - enum typedef `alu_op_e` (4 bits) holding the ten opcodes above.
  - constant XLEN_DEFAULT=32.
  - constant SHAMT_W=5.
- Sub-module `alu_shifter`: combinational SLL/SRL/SRA barrel shifter, inputs data, shamt and mode. This is the natural split; all other operations stay inline in alu.

Test Plan:
- Reset: drive r1=5, r2=3, ADD with reset_i=1 for 2 cycles -> `alu_result`=0 (and `zero_o`=1). Release reset -> 8 one cycle later.
- Arithmetic wrap:
  - ADD 0x7FFFFFFF+0x00000001 -> 0x80000000.
  - SUB 0x00000000-0x00000001 -> 0xFFFFFFFF.
  - SUB 7-7 -> 0, `zero_o`=1.
- Compares:
  - SLT(0xFFFFFFFF, 1) -> 1.
  - SLTU(0xFFFFFFFF, 1) -> 0.
  - SLT(0x80000000, 0x7FFFFFFF) -> 1.
  - SLT(5, 5) -> 0.
- Shifts:
  - SLL(1, 31) -> 0x80000000.
  - SLL(1, 0x21) -> 2 (masked shift amount).
  - SRL(0x80000000, 4) -> 0x08000000.
  - SRA(0x80000000, 4) -> 0xF8000000.
- Logic and reserved:
  - XOR(0xF0F0F0F0, 0xFF00FF00) -> 0x0FF00FF0.
  - OR -> 0xFFF0FFF0.
  - AND -> 0xF000F000.
  - code 1111 -> 0.
- Pipelining: change the operation every cycle ADD, SUB, AND with fixed r1=12, r2=10 -> results 22, 2, 8 on consecutive cycles, each one cycle after its inputs.
